// File: rtl/mem_access_ctrl_if.sv
// Core <-> controller <-> RAM signal bundle for mem_access_ctrl.
// master: the controller (drives PC, RAM address/RW/data, instruction and load results).
// slave : the surroundings (core handshakes plus RAM read data).
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 8
);
  // core side
  logic              i_start;
  logic              i_pc_load;
  logic [PC_W-1:0]   i_pc_value;
  logic [DATA_W-1:0] o_instr;
  logic              o_instr_valid;
  logic              i_instr_ack;
  logic              i_mem_req;
  logic              i_mem_wr;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic              o_mem_ready;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rdata_valid;
  // RAM side
  logic [PC_W-1:0]   o_PC;
  logic [ADDR_W-1:0] o_ramaddr;
  logic [1:0]        o_RW;
  logic [DATA_W-1:0] o_databus;
  logic [DATA_W-1:0] i_databus;
  logic [DATA_W-1:0] i_instrfetch;

  modport master (
    input  i_start, i_pc_load, i_pc_value, i_instr_ack, i_mem_req, i_mem_wr,
           i_mem_addr, i_mem_wdata, i_databus, i_instrfetch,
    output o_instr, o_instr_valid, o_mem_ready, o_rdata, o_rdata_valid,
           o_PC, o_ramaddr, o_RW, o_databus
  );

  modport slave (
    output i_start, i_pc_load, i_pc_value, i_instr_ack, i_mem_req, i_mem_wr,
           i_mem_addr, i_mem_wdata, i_databus, i_instrfetch,
    input  o_instr, o_instr_valid, o_mem_ready, o_rdata, o_rdata_valid,
           o_PC, o_ramaddr, o_RW, o_databus
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the RAM interface. Holds the PC, fetches
// instructions, and sequences single-cycle LDR/STR data accesses for the core.
// Ports:
//   Clk    - clock, all state on rising edge
//   Reset  - asynchronous, active-high reset
//   bus    - mem_access_ctrl_if.master: core handshakes (start, branch, instr,
//            mem req, load result) and RAM bus (PC, ramaddr, RW, databus).
// All outputs are registered except o_mem_ready.
module mem_access_ctrl #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 4,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_access_ctrl_if.master   bus
);

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_LDR  = 2'b01;
  localparam logic [1:0] RW_STR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_EXEC,
    S_LOAD,
    S_STORE
  } state_t;

  state_t              r_state,       w_state;
  logic [PC_W-1:0]     r_pc,          w_pc;
  logic [DATA_W-1:0]   r_instr,       w_instr;
  logic                r_instr_valid, w_instr_valid;
  logic [1:0]          r_rw,          w_rw;
  logic [ADDR_W-1:0]   r_ramaddr,     w_ramaddr;
  logic [DATA_W-1:0]   r_databus,     w_databus;
  logic [DATA_W-1:0]   r_rdata,       w_rdata;
  logic                r_rdata_valid, w_rdata_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_rw          <= RW_NONE;
      r_ramaddr     <= '0;
      r_databus     <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pc          <= w_pc;
      r_instr       <= w_instr;
      r_instr_valid <= w_instr_valid;
      r_rw          <= w_rw;
      r_ramaddr     <= w_ramaddr;
      r_databus     <= w_databus;
      r_rdata       <= w_rdata;
      r_rdata_valid <= w_rdata_valid;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_pc          = r_pc;
    w_instr       = r_instr;
    w_instr_valid = r_instr_valid;
    w_rw          = r_rw;
    w_ramaddr     = r_ramaddr;
    w_databus     = r_databus;
    w_rdata       = r_rdata;
    w_rdata_valid = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_rw = RW_NONE;
        if (bus.i_pc_load) w_pc = bus.i_pc_value;
        if (bus.i_start)   w_state = S_FETCH;
      end

      S_FETCH: begin
        w_rw = RW_NONE;
        if (bus.i_pc_load) begin
          // branch while fetching: the word at the old PC is dropped
          w_pc = bus.i_pc_value;
        end else begin
          w_instr       = bus.i_instrfetch;
          w_instr_valid = 1'b1;
          w_pc          = r_pc + PC_W'(1);
          w_state       = S_WAIT_EXEC;
        end
      end

      S_WAIT_EXEC: begin
        if (bus.i_pc_load) begin
          w_pc          = bus.i_pc_value;
          w_instr_valid = 1'b0;
          w_state       = S_FETCH;
        end else if (bus.i_mem_req) begin
          // address/data are captured only here and held through the access,
          // so the level-sensitive RAM never sees them move while RW is active
          w_ramaddr     = bus.i_mem_addr;
          w_instr_valid = 1'b0;
          if (bus.i_mem_wr) begin
            w_databus = bus.i_mem_wdata;
            w_rw      = RW_STR;
            w_state   = S_STORE;
          end else begin
            w_rw    = RW_LDR;
            w_state = S_LOAD;
          end
        end else if (bus.i_instr_ack) begin
          w_instr_valid = 1'b0;
          w_state       = S_FETCH;
        end
      end

      S_LOAD: begin
        w_rdata       = bus.i_databus;
        w_rdata_valid = 1'b1;
        w_rw          = RW_NONE;
        w_state       = S_FETCH;
        if (bus.i_pc_load) w_pc = bus.i_pc_value;
      end

      S_STORE: begin
        w_rw    = RW_NONE;
        w_state = S_FETCH;
        if (bus.i_pc_load) w_pc = bus.i_pc_value;
      end

      default: begin
        w_rw    = RW_NONE;
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.o_mem_ready   = (r_state == S_WAIT_EXEC) && !bus.i_pc_load;
  assign bus.o_instr       = r_instr;
  assign bus.o_instr_valid = r_instr_valid;
  assign bus.o_rdata       = r_rdata;
  assign bus.o_rdata_valid = r_rdata_valid;
  assign bus.o_PC          = r_pc;
  assign bus.o_ramaddr     = r_ramaddr;
  assign bus.o_RW          = r_rw;
  assign bus.o_databus     = r_databus;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(4), .PC_W(8)) bus ();

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(4), .PC_W(8), .PC_RESET(8'd0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // instruction memory: fixed pattern, A/B at 0/1, else 0x100+addr
  function automatic logic [31:0] imem(input logic [7:0] a);
    if (a == 8'd0) return 32'hA;
    if (a == 8'd1) return 32'hB;
    return 32'h100 + {24'd0, a};
  endfunction

  // data memory: level-sensitive read, write on edges where RW=STR
  logic [31:0] dmem [16];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < 16; k++) dmem[k] <= (k == 4) ? 32'hDEAD : 32'h0;
    end else if (bus.o_RW == 2'b10) begin
      dmem[bus.o_ramaddr] <= bus.o_databus;
    end
  end

  assign bus.i_instrfetch = imem(bus.o_PC);
  assign bus.i_databus    = dmem[bus.o_ramaddr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          start, pc_load, pc_val, ack, req, wr, addr;
    logic [31:0] wdata;
    int          e_v;
    logic [31:0] e_instr;
    int          e_pc, e_rw, e_addr;
    logic [31:0] e_db;
    int          e_rv;
    logic [31:0] e_rdata;
    int          e_rdy;
  } vec_t;

  vec_t vecs [24];

  task automatic clear_inputs();
    bus.i_start = 1'b0; bus.i_pc_load = 1'b0; bus.i_pc_value = 8'd0;
    bus.i_instr_ack = 1'b0; bus.i_mem_req = 1'b0; bus.i_mem_wr = 1'b0;
    bus.i_mem_addr = 4'd0; bus.i_mem_wdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    //            st pl pv  ak rq wr ad wdata         v  instr        pc   rw ad db            rv rdata         rdy
    vecs[0]  = '{1, 0, 0,   0, 0, 0, 0, 32'h0,        0, 32'h0,       0,   0, 0, 32'h0,        0, 32'h0,        0};
    vecs[1]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'hA,       1,   0, 0, 32'h0,        0, 32'h0,        1};
    vecs[2]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'hA,       1,   0, 0, 32'h0,        0, 32'h0,        1};
    vecs[3]  = '{0, 0, 0,   1, 0, 0, 0, 32'h0,        0, 32'hA,       1,   0, 0, 32'h0,        0, 32'h0,        0};
    vecs[4]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'hB,       2,   0, 0, 32'h0,        0, 32'h0,        1};
    vecs[5]  = '{0, 0, 0,   0, 1, 0, 4, 32'h0,        0, 32'hB,       2,   1, 4, 32'h0,        0, 32'h0,        0};
    vecs[6]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 32'hB,       2,   0, 4, 32'h0,        1, 32'hDEAD,     0};
    vecs[7]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h102,     3,   0, 4, 32'h0,        0, 32'hDEAD,     1};
    vecs[8]  = '{0, 0, 0,   0, 1, 1, 7, 32'h1234,     0, 32'h102,     3,   2, 7, 32'h1234,     0, 32'hDEAD,     0};
    vecs[9]  = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 32'h102,     3,   0, 7, 32'h1234,     0, 32'hDEAD,     0};
    vecs[10] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h103,     4,   0, 7, 32'h1234,     0, 32'hDEAD,     1};
    vecs[11] = '{0, 0, 0,   1, 1, 0, 4, 32'h0,        0, 32'h103,     4,   1, 4, 32'h1234,     0, 32'hDEAD,     0};
    vecs[12] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        0, 32'h103,     4,   0, 4, 32'h1234,     1, 32'hDEAD,     0};
    vecs[13] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h104,     5,   0, 4, 32'h1234,     0, 32'hDEAD,     1};
    vecs[14] = '{0, 1, 8,   0, 1, 1, 2, 32'h99,       0, 32'h104,     8,   0, 4, 32'h1234,     0, 32'hDEAD,     0};
    vecs[15] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h108,     9,   0, 4, 32'h1234,     0, 32'hDEAD,     1};
    vecs[16] = '{0, 1, 255, 1, 0, 0, 0, 32'h0,        0, 32'h108,     255, 0, 4, 32'h1234,     0, 32'hDEAD,     0};
    vecs[17] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h1FF,     0,   0, 4, 32'h1234,     0, 32'hDEAD,     1};
    vecs[18] = '{0, 0, 0,   1, 0, 0, 0, 32'h0,        0, 32'h1FF,     0,   0, 4, 32'h1234,     0, 32'hDEAD,     0};
    vecs[19] = '{0, 1, 48,  0, 0, 0, 0, 32'h0,        0, 32'h1FF,     48,  0, 4, 32'h1234,     0, 32'hDEAD,     0};
    vecs[20] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h130,     49,  0, 4, 32'h1234,     0, 32'hDEAD,     1};
    vecs[21] = '{0, 0, 0,   0, 1, 0, 7, 32'h0,        0, 32'h130,     49,  1, 7, 32'h1234,     0, 32'hDEAD,     0};
    vecs[22] = '{0, 1, 16,  0, 0, 0, 0, 32'h0,        0, 32'h130,     16,  0, 7, 32'h1234,     1, 32'h1234,     0};
    vecs[23] = '{0, 0, 0,   0, 0, 0, 0, 32'h0,        1, 32'h110,     17,  0, 7, 32'h1234,     0, 32'h1234,     1};

    Reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge Clk);

    chk("rst PC",      32'(bus.o_PC),          32'd0);
    chk("rst RW",      32'(bus.o_RW),          32'd0);
    chk("rst ramaddr", 32'(bus.o_ramaddr),     32'd0);
    chk("rst databus", bus.o_databus,          32'd0);
    chk("rst instr",   bus.o_instr,            32'd0);
    chk("rst ivalid",  32'(bus.o_instr_valid), 32'd0);
    chk("rst rdata",   bus.o_rdata,            32'd0);
    chk("rst rvalid",  32'(bus.o_rdata_valid), 32'd0);
    chk("rst ready",   32'(bus.o_mem_ready),   32'd0);

    Reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bus.i_start     = 1'(vecs[i].start);
      bus.i_pc_load   = 1'(vecs[i].pc_load);
      bus.i_pc_value  = 8'(vecs[i].pc_val);
      bus.i_instr_ack = 1'(vecs[i].ack);
      bus.i_mem_req   = 1'(vecs[i].req);
      bus.i_mem_wr    = 1'(vecs[i].wr);
      bus.i_mem_addr  = 4'(vecs[i].addr);
      bus.i_mem_wdata = vecs[i].wdata;
      tick();
      chk($sformatf("r%0d ivalid", i),  32'(bus.o_instr_valid), 32'(vecs[i].e_v));
      chk($sformatf("r%0d instr", i),   bus.o_instr,            vecs[i].e_instr);
      chk($sformatf("r%0d PC", i),      32'(bus.o_PC),          32'(vecs[i].e_pc));
      chk($sformatf("r%0d RW", i),      32'(bus.o_RW),          32'(vecs[i].e_rw));
      chk($sformatf("r%0d ramaddr", i), 32'(bus.o_ramaddr),     32'(vecs[i].e_addr));
      chk($sformatf("r%0d databus", i), bus.o_databus,          vecs[i].e_db);
      chk($sformatf("r%0d rvalid", i),  32'(bus.o_rdata_valid), 32'(vecs[i].e_rv));
      chk($sformatf("r%0d rdata", i),   bus.o_rdata,            vecs[i].e_rdata);
      chk($sformatf("r%0d ready", i),   32'(bus.o_mem_ready),   32'(vecs[i].e_rdy));
    end
    clear_inputs();
    chk("ram[7] after STR", dmem[7], 32'h1234);

    // o_mem_ready drops combinationally with a branch request in WAIT_EXEC
    bus.i_pc_load = 1'b1;
    #1;
    chk("ready w/ pc_load", 32'(bus.o_mem_ready), 32'd0);
    bus.i_pc_load = 1'b0;
    #1;
    chk("ready no pc_load", 32'(bus.o_mem_ready), 32'd1);

    // reset asserted in the middle of a STORE
    bus.i_mem_req = 1'b1; bus.i_mem_wr = 1'b1; bus.i_mem_addr = 4'd9; bus.i_mem_wdata = 32'h77;
    tick();
    clear_inputs();
    chk("pre-rst RW STR", 32'(bus.o_RW), 32'd2);
    Reset = 1'b1;
    #1;
    chk("midSTR RW",      32'(bus.o_RW),          32'd0);
    chk("midSTR ramaddr", 32'(bus.o_ramaddr),     32'd0);
    chk("midSTR databus", bus.o_databus,          32'd0);
    chk("midSTR PC",      32'(bus.o_PC),          32'd0);
    chk("midSTR instr",   bus.o_instr,            32'd0);
    chk("midSTR rdata",   bus.o_rdata,            32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // IDLE: no start -> nothing happens
    tick();
    chk("idle ivalid", 32'(bus.o_instr_valid), 32'd0);
    chk("idle PC",     32'(bus.o_PC),          32'd0);
    chk("idle RW",     32'(bus.o_RW),          32'd0);

    // branch while IDLE updates PC but stays IDLE
    bus.i_pc_load = 1'b1; bus.i_pc_value = 8'd5;
    tick();
    clear_inputs();
    chk("idle pcload PC", 32'(bus.o_PC), 32'd5);
    tick();
    chk("idle stays ivalid", 32'(bus.o_instr_valid), 32'd0);
    chk("idle stays PC",     32'(bus.o_PC),          32'd5);

    // restart fetches from the branched PC
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    chk("restart instr",  bus.o_instr,            32'h105);
    chk("restart PC",     32'(bus.o_PC),          32'd6);
    chk("restart ivalid", 32'(bus.o_instr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
